// File: rtl/uart_byte_receiver_pkg.sv
// Shared constants and helpers for the 8N1 serial byte receiver feeding the program loader.
package uart_byte_receiver_pkg;

   localparam int ICE_STICK_CLOCK_RATE = 12000000;
   localparam int UART_BAUD_RATE       = 115200;

   // Whole system clocks per serial bit; the fractional part is dropped.
   function automatic int cyclesPerBit(input int clockRate, input int baudRate);
      return clockRate / baudRate;
   endfunction

endpackage

// File: rtl/uart_byte_receiver_if.sv
// Serial line plus received-byte signals shared by the receiver (master) and the program loader (slave).
interface uart_byte_receiver_if;

   logic       rx;
   logic       rcv;
   logic [7:0] data;
   logic       frameError;
   logic       busy;

   modport master (
      input  rx,
      output rcv,
      output data,
      output frameError,
      output busy
   );

   modport slave (
      output rx,
      input  rcv,
      input  data,
      input  frameError,
      input  busy
   );

endinterface

// File: rtl/uart_byte_receiver_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; INIT sets the value held through reset.
module sync_2ff #(
   parameter logic INIT = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic metaR;
   logic stageR;

   // Metastability filter: two back-to-back capture stages.
   always_ff @(posedge clk) begin
      if (reset) begin
         metaR  <= INIT;
         stageR <= INIT;
      end else begin
         metaR  <= d;
         stageR <= metaR;
      end
   end

   assign q = stageR;

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 serial receiver: samples each bit at its centre, strobes rcv per good byte, flags bad stop bits.
module uart_byte_receiver
   import uart_byte_receiver_pkg::*;
#(
   parameter int clockRate = ICE_STICK_CLOCK_RATE,
   parameter int baudRate  = UART_BAUD_RATE
) (
   input  logic                   clk,
   input  logic                   reset,
   uart_byte_receiver_if.master   uart
);

   localparam int CPB  = cyclesPerBit(clockRate, baudRate);
   localparam int HALF = CPB / 2;
   localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

   localparam logic [CW-1:0] CNT_ZERO     = CW'(0);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);
   localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_BIT_END  = CW'(CPB - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;

   if (CPB < 4) begin : gCpbCheck
      $error("uart_byte_receiver: clockRate/baudRate must be at least 4");
   end

   logic          rxS;
   logic [2:0]    stateR;
   logic [CW-1:0] cntR;
   logic [2:0]    bitIdxR;
   logic [7:0]    shiftR;
   logic [7:0]    dataR;
   logic          rcvR;
   logic          frameErrorR;
   logic          lastBitS;
   logic          halfEndS;
   logic          bitEndS;

   sync_2ff #(.INIT(1'b1)) uRxSync (
      .clk   (clk),
      .reset (reset),
      .d     (uart.rx),
      .q     (rxS)
   );

   // Timer terminal counts and the explicit "eighth bit" flag.
   always_comb begin
      lastBitS = (bitIdxR == 3'd7);
      halfEndS = (cntR == CNT_HALF_END);
      bitEndS  = (cntR == CNT_BIT_END);
   end

   // Bit timer, frame FSM and output strobes; strobes default low so they last one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateR      <= ST_IDLE;
         cntR        <= CNT_ZERO;
         bitIdxR     <= 3'd0;
         shiftR      <= 8'h00;
         dataR       <= 8'h00;
         rcvR        <= 1'b0;
         frameErrorR <= 1'b0;
      end else begin
         rcvR        <= 1'b0;
         frameErrorR <= 1'b0;
         case (stateR)
            ST_IDLE: begin
               if (!rxS) begin
                  stateR <= ST_START;
                  cntR   <= CNT_ZERO;
               end
            end
            ST_START: begin
               if (halfEndS) begin
                  cntR    <= CNT_ZERO;
                  bitIdxR <= 3'd0;
                  stateR  <= rxS ? ST_IDLE : ST_DATA;
               end else begin
                  cntR <= cntR + CNT_ONE;
               end
            end
            ST_DATA: begin
               if (bitEndS) begin
                  cntR   <= CNT_ZERO;
                  shiftR <= {rxS, shiftR[7:1]};
                  if (lastBitS) begin
                     stateR <= ST_STOP;
                  end else begin
                     bitIdxR <= bitIdxR + 3'd1;
                  end
               end else begin
                  cntR <= cntR + CNT_ONE;
               end
            end
            // Leaving at the stop-bit centre lets an immediately following start edge be caught.
            ST_STOP: begin
               if (bitEndS) begin
                  cntR <= CNT_ZERO;
                  if (rxS) begin
                     dataR  <= shiftR;
                     rcvR   <= 1'b1;
                     stateR <= ST_IDLE;
                  end else begin
                     frameErrorR <= 1'b1;
                     stateR      <= ST_BREAK;
                  end
               end else begin
                  cntR <= cntR + CNT_ONE;
               end
            end
            ST_BREAK: begin
               if (rxS) begin
                  stateR <= ST_IDLE;
               end
            end
            default: begin
               stateR <= ST_IDLE;
               cntR   <= CNT_ZERO;
            end
         endcase
      end
   end

   assign uart.rcv        = rcvR;
   assign uart.data       = dataR;
   assign uart.frameError = frameErrorR;
   assign uart.busy       = (stateR != ST_IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver: a per-cycle timeline of expected outputs built from frame timing.
module tb_uart_byte_receiver;

   localparam int CLOCK_RATE = 1600;
   localparam int BAUD       = 100;
   localparam int CPB        = 16;
   localparam int HALF       = 8;
   localparam int LAT        = 2 + HALF + 9 * CPB + 1;
   localparam int MAXC       = 4000;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   uart_byte_receiver_if bus ();

   uart_byte_receiver #(
      .clockRate (CLOCK_RATE),
      .baudRate  (BAUD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .uart  (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit         expRcv  [MAXC];
   bit         expFe   [MAXC];
   bit         expBusy [MAXC];
   bit         dataSet [MAXC];
   logic [7:0] dataVal [MAXC];

   int nChecks = 0;
   int nFails  = 0;
   int rcvQ[$];
   int feQ[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic markBusy(input int a, input int b);
      for (int c = a; c <= b; c++) begin
         if (c >= 0 && c < MAXC) expBusy[c] = 1'b1;
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Registers expectations from frame timing, then drives start, 8 data bits LSB first, stop.
   task automatic sendFrame(input logic [7:0] b, input logic stopBit, output int t);
      logic [9:0] bits;
      t    = cyc;
      bits = {stopBit, b, 1'b0};
      markBusy(t + 3, t + LAT - 1);
      if (stopBit) begin
         expRcv[t + LAT]  = 1'b1;
         dataSet[t + LAT] = 1'b1;
         dataVal[t + LAT] = b;
      end else begin
         expFe[t + LAT] = 1'b1;
      end
      for (int k = 0; k < 10; k++) begin
         bus.rx = bits[k];
         waitCycles(CPB);
      end
   endtask

   logic [7:0] modelData = 8'h00;
   logic [7:0] prevData  = 8'h00;
   logic       prevRcv   = 1'b0;
   logic       prevFe    = 1'b0;
   logic       resetSeen = 1'b1;

   // Per-cycle comparison against the timeline plus the pulse/stability rules.
   always @(negedge clk) begin
      if (cyc >= 1 && cyc < MAXC) begin
         if (dataSet[cyc]) modelData = dataVal[cyc];
         chk("rcv", 32'(bus.rcv), 32'(expRcv[cyc]));
         chk("frameError", 32'(bus.frameError), 32'(expFe[cyc]));
         chk("busy", 32'(bus.busy), 32'(expBusy[cyc]));
         chk("data", 32'(bus.data), 32'(modelData));
         chk("rcvFeExclusive", 32'(bus.rcv & bus.frameError), 32'd0);
         chk("rcvSinglePulse", 32'(prevRcv & bus.rcv), 32'd0);
         chk("feSinglePulse", 32'(prevFe & bus.frameError), 32'd0);
         if (!resetSeen)
            chk("dataOnlyOnRcv", 32'((bus.data !== prevData) && !(bus.rcv && !prevRcv)), 32'd0);
         if (bus.rcv === 1'b1) rcvQ.push_back(cyc);
         if (bus.frameError === 1'b1) feQ.push_back(cyc);
         prevRcv   = bus.rcv;
         prevFe    = bus.frameError;
         prevData  = bus.data;
         resetSeen = reset;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int tA, tB, tC, tE, tE0, tF, tG, tH, tR;
      bus.rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("resetRcv", 32'(bus.rcv), 32'd0);
      chk("resetFe", 32'(bus.frameError), 32'd0);
      chk("resetBusy", 32'(bus.busy), 32'd0);
      chk("resetData", 32'(bus.data), 32'h00);
      waitCycles(20);

      // Single good frame and its exact latency.
      sendFrame(8'hA5, 1'b1, tA);
      waitCycles(10);
      chk("countA5", 32'(rcvQ.size()), 32'd1);
      if (rcvQ.size() >= 1) chk("latencyA5", 32'(rcvQ[0] - tA), 32'd155);
      chk("dataA5", 32'(bus.data), 32'hA5);
      waitCycles(10);

      // Back-to-back frames with no idle gap.
      sendFrame(8'h00, 1'b1, tB);
      sendFrame(8'hFF, 1'b1, tC);
      waitCycles(10);
      chk("countB2B", 32'(rcvQ.size()), 32'd3);
      if (rcvQ.size() >= 3) chk("spacingB2B", 32'(rcvQ[2] - rcvQ[1]), 32'd160);
      chk("dataFF", 32'(bus.data), 32'hFF);

      // Start-bit glitch of 4 cycles.
      tG = cyc;
      markBusy(tG + 3, tG + 2 + HALF);
      bus.rx = 1'b0;
      waitCycles(4);
      bus.rx = 1'b1;
      waitCycles(30);
      chk("glitchNoRcv", 32'(rcvQ.size()), 32'd3);
      chk("glitchNoFe", 32'(feQ.size()), 32'd0);
      chk("glitchBusy", 32'(bus.busy), 32'd0);

      // Bad stop bit, line held low, then a good frame.
      tE0 = cyc;
      markBusy(tE0 + LAT, tE0 + 10 * CPB + 50 + 2);
      sendFrame(8'h3C, 1'b0, tE);
      waitCycles(45);
      chk("breakBusy", 32'(bus.busy), 32'd1);
      waitCycles(5);
      bus.rx = 1'b1;
      waitCycles(20);
      chk("feCount", 32'(feQ.size()), 32'd1);
      if (feQ.size() >= 1) chk("feLatency", 32'(feQ[0] - tE), 32'd155);
      chk("feNoRcv", 32'(rcvQ.size()), 32'd3);
      chk("feDataKept", 32'(bus.data), 32'hFF);
      sendFrame(8'h12, 1'b1, tF);
      waitCycles(10);
      chk("data12", 32'(bus.data), 32'h12);
      waitCycles(10);

      // Reset during data bit 3 of 0x5A.
      tR = cyc;
      markBusy(tR + 3, tR + 70);
      dataSet[tR + 71] = 1'b1;
      dataVal[tR + 71] = 8'h00;
      bus.rx = 1'b0; waitCycles(CPB);
      bus.rx = 1'b0; waitCycles(CPB);
      bus.rx = 1'b1; waitCycles(CPB);
      bus.rx = 1'b0; waitCycles(CPB);
      bus.rx = 1'b1; waitCycles(6);
      reset = 1'b1;
      waitCycles(1);
      reset = 1'b0;
      chk("midResetBusy", 32'(bus.busy), 32'd0);
      chk("midResetData", 32'(bus.data), 32'h00);
      waitCycles(20);
      chk("midResetNoRcv", 32'(rcvQ.size()), 32'd4);
      sendFrame(8'h81, 1'b1, tH);
      waitCycles(10);
      chk("data81", 32'(bus.data), 32'h81);
      chk("finalRcvCount", 32'(rcvQ.size()), 32'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
